// File: rtl/flash_word_reader.sv
// Word reader for the DE2-115 parallel NOR flash in byte mode: reset pulse,
// then two byte reads per toggle request, assembled big-endian into 16 bits.
`timescale 1ns/1ps
module flash_word_reader #(
  parameter int READ_CYCLES    = 6,
  parameter int RST_LOW_CYCLES = 32,
  parameter int RST_REC_CYCLES = 4
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        ireq,
  input  logic [22:0] iaddr,
  output logic        oack,
  output logic [15:0] odata,
  output logic        oready,
  output logic [22:0] ofl_addr,
  input  logic [7:0]  ifl_dq,
  output logic        ofl_ce_n,
  output logic        ofl_oe_n,
  output logic        ofl_we_n,
  output logic        ofl_rst_n,
  output logic        ofl_wp_n,
  output logic [2:0]  odbg_state
);

  // Handshake: a request is pending whenever the synchronized ireq level
  // differs from oack; oack is set equal to that level once odata is valid.

  typedef enum logic [2:0] {
    ST_RST_LOW = 3'd0,
    ST_RST_REC = 3'd1,
    ST_IDLE    = 3'd2,
    ST_READ_LO = 3'd3,
    ST_READ_HI = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [7:0] LOW_LAST = 8'(RST_LOW_CYCLES - 1);
  localparam logic [7:0] REC_LAST = 8'(RST_REC_CYCLES - 1);
  localparam logic [7:0] RD_LAST  = 8'(READ_CYCLES - 1);

  state_t     state, state_n;
  logic [7:0] cnt;
  logic       req_s1, req_s2;
  logic [7:0] hi_byte, lo_byte;
  logic       pending;
  logic       unused_addr_lsb;

  assign unused_addr_lsb = iaddr[0];
  assign pending    = (req_s2 != oack);
  assign ofl_we_n   = 1'b1;
  assign ofl_wp_n   = 1'b1;
  assign odbg_state = state;

  always_comb begin
    state_n = state;
    case (state)
      ST_RST_LOW: if (cnt == LOW_LAST) state_n = ST_RST_REC;
      ST_RST_REC: if (cnt == REC_LAST) state_n = ST_IDLE;
      ST_IDLE:    if (pending)         state_n = ST_READ_LO;
      ST_READ_LO: if (cnt == RD_LAST)  state_n = ST_READ_HI;
      ST_READ_HI: if (cnt == RD_LAST)  state_n = ST_DONE;
      ST_DONE:                         state_n = ST_IDLE;
      default:                         state_n = ST_RST_LOW;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state     <= ST_RST_LOW;
      cnt       <= 8'd0;
      req_s1    <= 1'b0;
      req_s2    <= 1'b0;
      oack      <= 1'b0;
      odata     <= 16'd0;
      oready    <= 1'b0;
      ofl_addr  <= 23'd0;
      ofl_ce_n  <= 1'b1;
      ofl_oe_n  <= 1'b1;
      ofl_rst_n <= 1'b0;
      hi_byte   <= 8'd0;
      lo_byte   <= 8'd0;
    end else begin
      req_s1 <= ireq;
      req_s2 <= req_s1;
      state  <= state_n;
      if (state_n != state || state == ST_IDLE) cnt <= 8'd0;
      else                                      cnt <= cnt + 8'd1;
      // Flash pins are registered from the next state so they stay glitch-free.
      ofl_ce_n  <= !(state_n == ST_READ_LO || state_n == ST_READ_HI);
      ofl_oe_n  <= !(state_n == ST_READ_LO || state_n == ST_READ_HI);
      ofl_rst_n <= (state_n != ST_RST_LOW);
      if (state == ST_RST_REC && state_n == ST_IDLE) oready <= 1'b1;
      if (state == ST_IDLE && state_n == ST_READ_LO) ofl_addr <= {iaddr[22:1], 1'b0};
      if (state == ST_READ_LO && state_n == ST_READ_HI) begin
        hi_byte     <= ifl_dq;
        ofl_addr[0] <= 1'b1;
      end
      if (state == ST_READ_HI && state_n == ST_DONE) lo_byte <= ifl_dq;
      if (state == ST_DONE) begin
        odata <= {hi_byte, lo_byte};
        oack  <= req_s2;
      end
    end
  end

endmodule

// File: tb/tb_flash_word_reader.sv
// Randomized bench for flash_word_reader: behavioural flash image, word
// scoreboard, access monitor on the flash pins and reset-sequence timing.
`timescale 1ns/1ps
module tb_flash_word_reader;

  localparam int READ_CYCLES = 6;
  localparam int RST_LOW     = 32;
  localparam int RST_REC     = 4;
  localparam int LAT         = 2 + 2 * READ_CYCLES + 2;

  // ---------------- clock / reset ----------------
  logic        iclk = 1'b0;
  logic        ireset = 1'b1;
  logic        ireq = 1'b0;
  logic [22:0] iaddr = 23'd0;
  logic        oack, oready;
  logic [15:0] odata;
  logic [22:0] ofl_addr;
  logic [7:0]  ifl_dq;
  logic        ofl_ce_n, ofl_oe_n, ofl_we_n, ofl_rst_n, ofl_wp_n;
  logic [2:0]  odbg_state;
  logic [7:0]  salt = 8'h00;

  always #10 iclk = ~iclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  flash_word_reader #(
    .READ_CYCLES(READ_CYCLES), .RST_LOW_CYCLES(RST_LOW), .RST_REC_CYCLES(RST_REC)
  ) dut (
    .iclk(iclk), .ireset(ireset), .ireq(ireq), .iaddr(iaddr),
    .oack(oack), .odata(odata), .oready(oready), .ofl_addr(ofl_addr),
    .ifl_dq(ifl_dq), .ofl_ce_n(ofl_ce_n), .ofl_oe_n(ofl_oe_n),
    .ofl_we_n(ofl_we_n), .ofl_rst_n(ofl_rst_n), .ofl_wp_n(ofl_wp_n),
    .odbg_state(odbg_state)
  );

  // ---------------- flash image model ----------------
  function automatic logic [7:0] flash_byte(input logic [22:0] a, input logic [7:0] s);
    logic [22:0] t;
    if (a == 23'h000100) return 8'h12;
    if (a == 23'h000101) return 8'h34;
    t = a ^ (a >> 8) ^ (a >> 16);
    return t[7:0] ^ s;
  endfunction

  function automatic logic [15:0] model_word(input logic [22:0] a);
    logic [22:0] even;
    even = a & 23'h7FFFFE;
    return {flash_byte(even, salt), flash_byte(even + 23'd1, salt)};
  endfunction

  assign ifl_dq = (!ofl_ce_n && !ofl_oe_n) ? flash_byte(ofl_addr, salt) : 8'hFF;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- pin monitor ----------------
  int          run_len = 0;
  logic [22:0] run_a0, run_a1;
  int          viol_const = 0, viol_oe = 0, viol_early = 0;
  int          obs_len_q[$];
  logic [22:0] obs_a0_q[$];
  logic [22:0] obs_a1_q[$];

  always @(negedge iclk) begin
    if (ofl_we_n !== 1'b1 || ofl_wp_n !== 1'b1) viol_const++;
    if (ofl_ce_n !== ofl_oe_n) viol_oe++;
    if (ofl_ce_n === 1'b0 && oready !== 1'b1) viol_early++;
    if (ofl_ce_n === 1'b0) begin
      run_len++;
      if (run_len == 1) run_a0 = ofl_addr;
      if (run_len == READ_CYCLES + 1) run_a1 = ofl_addr;
    end else if (run_len > 0) begin
      obs_len_q.push_back(run_len);
      obs_a0_q.push_back(run_a0);
      obs_a1_q.push_back(run_a1);
      run_len = 0;
    end
  end

  // ---------------- scoreboard / drivers ----------------
  logic [15:0] exp_q[$];
  logic [22:0] exp_addr_q[$];

  task automatic tick();
    @(negedge iclk);
  endtask

  task automatic do_reset();
    ireset = 1'b1;
    ireq   = 1'b0;
    repeat (3) tick();
    check_eq("rst_oack", oack, 0);
    check_eq("rst_odata", odata, 0);
    check_eq("rst_oready", oready, 0);
    check_eq("rst_fl_addr", ofl_addr, 0);
    check_eq("rst_ce_oe", {ofl_ce_n, ofl_oe_n, ofl_rst_n}, 3'b110);
    exp_q.delete();
    exp_addr_q.delete();
    obs_len_q.delete();
    obs_a0_q.delete();
    obs_a1_q.delete();
    run_len = 0;
    ireset  = 1'b0;
  endtask

  task automatic check_reset_seq(input string tag);
    int low = 0;
    int rec = 0;
    while (ofl_rst_n === 1'b0 && low < 200) begin
      low++;
      tick();
    end
    check_eq({tag, "_rst_low_cycles"}, low, RST_LOW);
    while (oready !== 1'b1 && rec < 200) begin
      tick();
      rec++;
    end
    check_eq({tag, "_rec_cycles"}, rec, RST_REC);
  endtask

  task automatic issue(input logic [22:0] a);
    iaddr = a;
    exp_q.push_back(model_word(a));
    exp_addr_q.push_back(a & 23'h7FFFFE);
    ireq = ~ireq;
  endtask

  task automatic wait_ack(input int exp_lat, input string tag);
    int          k = 0;
    logic [15:0] w;
    logic [22:0] ea;
    while (oack !== ireq && k < 200) begin
      tick();
      k++;
    end
    check_eq({tag, "_ack"}, oack, ireq);
    if (exp_lat >= 0) check_eq({tag, "_latency"}, k, exp_lat);
    w  = exp_q.pop_front();
    ea = exp_addr_q.pop_front();
    check_eq({tag, "_data"}, odata, w);
    if (obs_len_q.size() == 0) begin
      check_eq({tag, "_access_seen"}, 0, 1);
    end else begin
      check_eq({tag, "_access_len"}, obs_len_q.pop_front(), 2 * READ_CYCLES);
      check_eq({tag, "_addr_even"}, obs_a0_q.pop_front(), ea);
      check_eq({tag, "_addr_odd"}, obs_a1_q.pop_front(), ea | 23'd1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    salt = 8'($urandom);

    do_reset();
    check_reset_seq("rst1");

    tick();
    issue(23'h000100);
    wait_ack(LAT, "single");
    check_eq("single_big_endian", odata, 16'h1234);

    tick();
    issue(23'h000101);
    wait_ack(LAT, "odd_addr");
    check_eq("odd_big_endian", odata, 16'h1234);

    for (int i = 0; i < 4; i++) begin
      issue(23'h7FFFF8 + 23'(2 * i));
      wait_ack(LAT, "b2b");
    end

    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      issue(23'($urandom_range(0, 32'h7FFFFF)));
      wait_ack(LAT, "rand");
    end

    // Request raised while the flash is still in its reset sequence.
    do_reset();
    repeat (5) tick();
    issue(23'h000200);
    k = 0;
    while (oready !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    check_eq("rdr_ce_at_ready", ofl_ce_n, 1);
    tick();
    check_eq("rdr_ce_first_idle", ofl_ce_n, 0);
    wait_ack(-1, "rdr");

    // Reset landing in the middle of the high-address byte read.
    tick();
    issue(23'h000300);
    repeat (10) tick();
    check_eq("mid_in_access", ofl_ce_n, 0);
    ireset = 1'b1;
    tick();
    check_eq("mid_ce_oe_high", {ofl_ce_n, ofl_oe_n}, 2'b11);
    check_eq("mid_oack_zero", oack, 0);
    check_eq("mid_rst_low", ofl_rst_n, 0);
    do_reset();
    check_reset_seq("rst2");
    tick();
    issue(23'($urandom_range(0, 32'h7FFFFF)));
    wait_ack(LAT, "post_reset");

    check_eq("we_wp_constant", viol_const, 0);
    check_eq("ce_oe_together", viol_oe, 0);
    check_eq("ce_before_ready", viol_early, 0);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
